// File: rtl/pll_reset_sequencer_if.sv
// PLL lock / reset-release signal bundle for pll_reset_sequencer.
// The slave modport is the sequencer; the master modport is whoever supplies lock status and sw requests.
interface pll_reset_sequencer_if;
    logic       pll_locked;
    logic       sw_reset_req;
    logic       pll_rst;
    logic       rst_mem_n;
    logic       rst_core_n;
    logic [2:0] state;
    logic [7:0] lock_loss_cnt;

    // No valid/ready handshake here: pll_locked is a level, sw_reset_req is a
    // one-cycle pulse, and every output is a level that the sequencer holds
    // until its state changes.
    modport master (
        output pll_locked,
        output sw_reset_req,
        input  pll_rst,
        input  rst_mem_n,
        input  rst_core_n,
        input  state,
        input  lock_loss_cnt
    );

    modport slave (
        input  pll_locked,
        input  sw_reset_req,
        output pll_rst,
        output rst_mem_n,
        output rst_core_n,
        output state,
        output lock_loss_cnt
    );
endinterface

// File: rtl/pll_reset_sequencer.sv
// Sequences PLL reset, lock qualification and ordered mem/core reset release on the reference clock.
// Optional: define PLL_RST_SEQ_LOSS_CNT_EN to implement the saturating lock_loss_cnt counter.
module pll_reset_sequencer #(
    parameter int PLL_RST_CYCLES = 8,
    parameter int LOCK_STABLE    = 256,
    parameter int STAGE_DELAY    = 16,
    parameter int LOCK_TIMEOUT   = 65535,
    parameter int CNT_W          = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    pll_reset_sequencer_if.slave  bus
);

    typedef enum logic [2:0] {
        S_PLL_RST   = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_REL_MEM   = 3'd3,
        S_RUN       = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] PLL_RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE - 1);
    localparam logic [CNT_W-1:0] STAGE_LAST   = CNT_W'(STAGE_DELAY - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       sync_q;
    logic             locked_s;
    logic             restart;
    logic             pll_rst_q;
    logic             rst_mem_n_q;
    logic             rst_core_n_q;

    assign locked_s = sync_q[1];

    always_comb begin
        state_d = state_q;
        if (bus.sw_reset_req) begin
            state_d = S_PLL_RST;
        end else begin
            unique case (state_q)
                S_PLL_RST: begin
                    if (cnt == PLL_RST_LAST) state_d = S_WAIT_LOCK;
                end
                S_WAIT_LOCK: begin
                    if (locked_s)                 state_d = S_STABLE;
                    else if (cnt == TIMEOUT_LAST) state_d = S_PLL_RST;
                end
                S_STABLE: begin
                    if (!locked_s)               state_d = S_WAIT_LOCK;
                    else if (cnt == STABLE_LAST) state_d = S_REL_MEM;
                end
                S_REL_MEM: begin
                    if (!locked_s)              state_d = S_WAIT_LOCK;
                    else if (cnt == STAGE_LAST) state_d = S_RUN;
                end
                S_RUN: begin
                    if (!locked_s) state_d = S_WAIT_LOCK;
                end
                default: state_d = S_PLL_RST;
            endcase
        end
    end

    // A sw request clears the counter even when already in PLL_RST, restarting the pulse.
    assign restart = bus.sw_reset_req || (state_d != state_q);

    // Outputs decode state_d so they flip on the same edge as state; the async
    // reset drives each flop straight to its asserted value, so *_n never glitch high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q       <= 2'b00;
            state_q      <= S_PLL_RST;
            cnt          <= '0;
            pll_rst_q    <= 1'b1;
            rst_mem_n_q  <= 1'b0;
            rst_core_n_q <= 1'b0;
        end else begin
            sync_q       <= {sync_q[0], bus.pll_locked};
            state_q      <= state_d;
            cnt          <= restart ? '0 : cnt + 1'b1;
            pll_rst_q    <= (state_d == S_PLL_RST);
            rst_mem_n_q  <= (state_d == S_REL_MEM) || (state_d == S_RUN);
            rst_core_n_q <= (state_d == S_RUN);
        end
    end

    assign bus.pll_rst    = pll_rst_q;
    assign bus.rst_mem_n  = rst_mem_n_q;
    assign bus.rst_core_n = rst_core_n_q;
    assign bus.state      = state_q;

`ifdef PLL_RST_SEQ_LOSS_CNT_EN
    logic       lock_loss;
    logic [7:0] loss_cnt;

    // Only losses after release count; a simultaneous sw request wins and is not a loss.
    assign lock_loss = !bus.sw_reset_req && !locked_s &&
                       ((state_q == S_REL_MEM) || (state_q == S_RUN));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            loss_cnt <= 8'd0;
        end else if (lock_loss && (loss_cnt != 8'hFF)) begin
            loss_cnt <= loss_cnt + 8'd1;
        end
    end

    assign bus.lock_loss_cnt = loss_cnt;
`else
    assign bus.lock_loss_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Self-checking bench for pll_reset_sequencer: expected outputs per edge are derived from the
// documented release/loss/timeout timings, queued by the driver and compared by a monitor.
module tb_pll_reset_sequencer;

    localparam int PRC = 8;
    localparam int LS  = 16;
    localparam int SD  = 4;
    localparam int LT  = 100;

    typedef logic [13:0] vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    vec_t       exp_q[$];
    string      tag_q[$];
    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] exp_llc = 8'd0;

    pll_reset_sequencer_if bus ();

    pll_reset_sequencer #(
        .PLL_RST_CYCLES (PRC),
        .LOCK_STABLE    (LS),
        .STAGE_DELAY    (SD),
        .LOCK_TIMEOUT   (LT),
        .CNT_W          (16)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic vec_t mk(input bit pr, input bit mem, input bit core, input int st);
        return {pr, mem, core, 3'(st), exp_llc};
    endfunction

    function automatic vec_t v_pll();  return mk(1'b1, 1'b0, 1'b0, 0); endfunction
    function automatic vec_t v_wait(); return mk(1'b0, 1'b0, 1'b0, 1); endfunction
    function automatic vec_t v_run();  return mk(1'b0, 1'b1, 1'b1, 4); endfunction

    // Sitting in WAIT_LOCK with pll_locked held high from edge e onward.
    function automatic vec_t from_wait(input int k, input int e);
        if (k < e + 2)           return v_wait();
        if (k < e + 2 + LS)      return mk(1'b0, 1'b0, 1'b0, 2);
        if (k < e + 2 + LS + SD) return mk(1'b0, 1'b1, 1'b0, 3);
        return v_run();
    endfunction

    function automatic void bump();
`ifdef PLL_RST_SEQ_LOSS_CNT_EN
        if (exp_llc != 8'hFF) exp_llc = exp_llc + 8'd1;
`endif
    endfunction

    function automatic vec_t observed();
        return {bus.pll_rst, bus.rst_mem_n, bus.rst_core_n, bus.state, bus.lock_loss_cnt};
    endfunction

    // ---------------- scoreboard monitor ----------------
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            check(tag_q.pop_front(), 32'(observed()), 32'(exp_q.pop_front()));
        end
    end

    // ---------------- driver ----------------
    task automatic cycle(input bit lk, input bit sw, input vec_t e, input bit chk, input string tag);
        bus.pll_locked   = lk;
        bus.sw_reset_req = sw;
        if (chk) begin
            exp_q.push_back(e);
            tag_q.push_back(tag);
        end
        @(posedge clk);
        #2;
    endtask

    task automatic power_up();
        vec_t e;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 45; k++) begin
            e = (k < PRC) ? v_pll() : from_wait(k, 20);
            cycle(k >= 20, 1'b0, e, 1'b1, $sformatf("pwrup_e%0d", k));
        end
    endtask

    // From RUN: lose lock for edges 1..5, re-lock from edge 6.
    task automatic loss_relock(input bit chk, input string name, input int n);
        vec_t e;
        for (int k = 1; k <= n; k++) begin
            if (k == 3) bump();
            e = (k < 3) ? v_run() : from_wait(k, 6);
            cycle(k >= 6, 1'b0, e, chk, $sformatf("%s_e%0d", name, k));
        end
    endtask

    initial begin
        vec_t e;
        int   j;
        bus.pll_locked   = 1'b0;
        bus.sw_reset_req = 1'b0;

        // Reset values while rst_n is low.
        repeat (3) @(posedge clk);
        #2;
        check("reset_vals", 32'(observed()), 32'(v_pll()));

        power_up();

        // sw request on the same edge as lock loss, a second request mid-pulse,
        // then a one-cycle glitch 10 cycles into STABLE.
        for (int k = 1; k <= 60; k++) begin
            if (k < 3)       e = v_run();
            else if (k < 14) e = v_pll();
            else if (k < 34) e = from_wait(k, 20);
            else             e = from_wait(k, 33);
            cycle((k >= 20) && (k != 32), (k == 3) || (k == 6), e, 1'b1, $sformatf("sw_glitch_e%0d", k));
        end

        // Lock loss in RUN followed by re-lock.
        loss_relock(1'b1, "loss_run", 30);

        // Lock held low: WAIT_LOCK timeout re-pulses pll_rst repeatedly, then re-lock.
        for (int k = 1; k <= 250; k++) begin
            if (k == 3) bump();
            if (k < 3) begin
                e = v_run();
            end else if (k < 228) begin
                j = (k - 3) % (LT + PRC);
                e = (j < LT) ? v_wait() : v_pll();
            end else begin
                e = from_wait(k, 226);
            end
            cycle(k >= 226, 1'b0, e, 1'b1, $sformatf("timeout_e%0d", k));
        end

        // Saturation of the loss counter.
        for (int i = 0; i < 260; i++) begin
            loss_relock(1'b0, "sat", 30);
            check($sformatf("sat_llc_%0d", i), 32'(bus.lock_loss_cnt), 32'(exp_llc));
        end
        check("sat_state", 32'(bus.state), 32'd4);

        // Asynchronous reset in the middle of REL_MEM.
        loss_relock(1'b1, "pre_arst", 25);
        #1;
        rst_n = 1'b0;
        exp_llc = 8'd0;
        #1;
        check("arst_vals", 32'(observed()), 32'(v_pll()));
        repeat (2) @(posedge clk);
        #2;
        check("arst_hold", 32'(observed()), 32'(v_pll()));

        power_up();

        repeat (2) @(posedge clk);
        #2;
        check("drain", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
